// File: rtl/fetch_buf_pkg.sv
// Shared constants and entry layout for the fetch buffer between IF and ID.
// The bypass build of fetch_buf is selected with FETCH_BUF_BYPASS_EN.
package fetch_buf_pkg;

    localparam int FB_XLEN = 32;

    // ADDI x0, x0, 0: decodes as a legal instruction with no side effects.
    localparam logic [31:0] FB_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [FB_XLEN-1:0] pc;
        logic [FB_XLEN-1:0] instr;
        logic               pred_taken;
        logic [FB_XLEN-1:0] pred_target;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Circular fetch buffer decoupling IF from ID; flush/reset empty it in one cycle.
// Define FETCH_BUF_BYPASS_EN to forward an entry arriving at an empty buffer straight to ID.
module fetch_buf
    import fetch_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = FB_XLEN
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_fetch_vld,
    input  logic [XLEN-1:0]          i_fetch_pc,
    input  logic [XLEN-1:0]          i_fetch_instr,
    input  logic                     i_fetch_pred_taken,
    input  logic [XLEN-1:0]          i_fetch_pred_target,
    output logic                     o_fetch_rdy,
    input  logic                     i_flush,
    input  logic                     i_id_rdy,
    output logic                     o_id_vld,
    output logic [XLEN-1:0]          o_id_pc,
    output logic [XLEN-1:0]          o_id_instr,
    output logic                     o_id_pred_taken,
    output logic [XLEN-1:0]          o_id_pred_target,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] NOP_W = XLEN'(FB_NOP);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic [XLEN-1:0]  r_pc          [DEPTH];
    logic [XLEN-1:0]  r_instr       [DEPTH];
    logic             r_pred_taken  [DEPTH];
    logic [XLEN-1:0]  r_pred_target [DEPTH];

    logic [CW-1:0]    w_count;
    logic             w_stored_vld;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;
    logic             w_wr_en;
    logic             w_rd_en;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign w_stored_vld = (w_count != '0);
    assign w_wr_idx     = r_wr_ptr[AW-1:0];
    assign w_rd_idx     = r_rd_ptr[AW-1:0];

    // Space is judged on current occupancy only, so a pop never frees room for a push at full.
    assign o_fetch_rdy  = (w_count < CW'(DEPTH));
    assign o_count      = w_count;

    assign w_push       = i_fetch_vld && o_fetch_rdy && !i_flush;

`ifdef FETCH_BUF_BYPASS_EN
    assign w_bypass     = w_push && !w_stored_vld;
`else
    assign w_bypass     = 1'b0;
`endif

    assign o_id_vld     = w_stored_vld || w_bypass;
    assign w_pop        = o_id_vld && i_id_rdy && !i_flush;

    // A bypassed entry that ID takes immediately never occupies a slot.
    assign w_wr_en      = w_push && !(w_bypass && i_id_rdy);
    assign w_rd_en      = w_pop && w_stored_vld;

    always_comb begin
        o_id_pc          = '0;
        o_id_instr       = NOP_W;
        o_id_pred_taken  = 1'b0;
        o_id_pred_target = '0;
        if (w_stored_vld) begin
            o_id_pc          = r_pc[w_rd_idx];
            o_id_instr       = r_instr[w_rd_idx];
            o_id_pred_taken  = r_pred_taken[w_rd_idx];
            o_id_pred_target = r_pred_target[w_rd_idx];
        end
`ifdef FETCH_BUF_BYPASS_EN
        else if (w_bypass) begin
            o_id_pc          = i_fetch_pc;
            o_id_instr       = i_fetch_instr;
            o_id_pred_taken  = i_fetch_pred_taken;
            o_id_pred_target = i_fetch_pred_target;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Entry storage is not cleared; the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_wr_en && !i_reset) begin
            r_pc[w_wr_idx]          <= i_fetch_pc;
            r_instr[w_wr_idx]       <= i_fetch_instr;
            r_pred_taken[w_wr_idx]  <= i_fetch_pred_taken;
            r_pred_target[w_wr_idx] <= i_fetch_pred_target;
        end
    end

endmodule

// File: doc/fetch_buf.md
FETCH_BUF -- requirements
Module: fetch_buf

Interface
REQ-001 Parameter DEPTH, default 4; entry count, power of two, minimum 2.
REQ-002 Parameter XLEN, default 32; PC and instruction width.
REQ-003 i_clk  input  1  Single clock. All state updates on the rising edge.
REQ-004 i_reset  input  1  Reset, synchronous and active-high.
REQ-005 i_fetch_vld  input  1  IF presents a fetched entry this cycle.
REQ-006 i_fetch_pc  input  XLEN  PC of the fetched instruction.
REQ-007 i_fetch_instr  input  XLEN  Fetched instruction word.
REQ-008 i_fetch_pred_taken  input  1  Predictor taken decision for this PC.
REQ-009 i_fetch_pred_target  input  XLEN  Predicted target, meaningful when taken.
REQ-010 o_fetch_rdy  output  1  Buffer can accept an entry this cycle.
REQ-011 i_flush  input  1  Mispredict or redirect; discard all entries.
REQ-012 i_id_rdy  input  1  ID accepts the head entry; low means the hazard unit is stalling ID.
REQ-013 o_id_vld  output  1  Head entry valid toward ID.
REQ-014 o_id_pc, o_id_instr, o_id_pred_target  output  XLEN each  Head entry fields.
REQ-015 o_id_pred_taken  output  1  Head entry prediction.
REQ-016 o_count  output  $clog2(DEPTH)+1  Current occupancy.

Function
REQ-017 Push when i_fetch_vld && o_fetch_rdy && !i_flush; pop when o_id_vld && i_id_rdy && !i_flush.
REQ-018 o_fetch_rdy = (o_count < DEPTH); a pop in the same cycle does not free space for a push at full.
REQ-019 Storage is a circular buffer with write and read pointers that wrap modulo DEPTH. Occupancy is tracked with an extra pointer bit.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged and advances both pointers.
REQ-021 Without bypass, an entry pushed in cycle N is visible on o_id_* in cycle N+1 at the earliest.
REQ-022 When o_id_vld = 0, o_id_instr = NOP (32'h0000_0013), o_id_pred_taken = 0, and o_id_pc and o_id_pred_target = 0. ID then decodes a valid ADDI with no side effects.
REQ-023 When i_id_rdy = 0, the head entry and all o_id_* stay stable. Entries are never reordered or duplicated.
REQ-024 On i_flush, in the next cycle count = 0, pointers = 0 and o_id_vld = 0. A push or pop in the flush cycle is ignored.
REQ-025 i_flush has priority over push and pop; i_reset has priority over i_flush.
REQ-026 o_id_* are driven only from registered state, except in bypass mode (REQ-030).

Reset
REQ-027 On i_reset, all of the following hold from the next edge: pointers = 0, count = 0, o_id_vld = 0, o_fetch_rdy = 1 (combinational from count), o_id_instr = NOP.
REQ-028 Reset asserted mid-operation discards all entries exactly as flush does. Entry storage contents need not be cleared.

Configuration
REQ-029 Macro FETCH_BUF_BYPASS_EN selects the bypass mode.
REQ-030 With FETCH_BUF_BYPASS_EN defined: when count = 0 and a push occurs, the incoming entry drives o_id_* combinationally in the same cycle with o_id_vld = 1. If i_id_rdy = 1, the entry is consumed without being written and count stays 0; otherwise it is written normally.
REQ-031 Without FETCH_BUF_BYPASS_EN: no combinational path exists from any i_fetch_* input to o_id_*, and the REQ-021 latency holds.

Structure
REQ-032 A shared package holds:
- the NOP constant (32'h0000_0013);
- a packed struct typedef fetch_entry_t {pc, instr, pred_taken, pred_target};
- the XLEN default.
REQ-033 Storage and pointer logic stay inline; the block has no sub-module.

Verification
REQ-034 Reset, then push PC 0x00, 0x04 and 0x08 with i_id_rdy = 1 -> o_id_pc shows 0x00, 0x04, 0x08 on consecutive cycles, each one cycle after its push (no bypass).
REQ-035 Hold i_id_rdy = 0 and push DEPTH = 4 entries -> o_count = 4, o_fetch_rdy = 0, and a fifth push is dropped. Release i_id_rdy -> entries drain in order.
REQ-036 count = 2 with simultaneous push and pop across the pointer wrap (write pointer 3 -> 0) -> count stays 2 and FIFO order is preserved.
REQ-037 i_flush with count = 3 and a concurrent push of PC 0x40 -> next cycle o_id_vld = 0, o_id_instr = 0x00000013, o_count = 0, and 0x40 is never presented.
REQ-038 Entry PC 0x10 with pred_taken = 1 and target 0x80 is stalled 3 cycles by i_id_rdy = 0 -> fields stay stable and are popped unchanged.
REQ-039 With FETCH_BUF_BYPASS_EN defined, empty buffer, push PC 0x20 with i_id_rdy = 1 -> o_id_pc = 0x20 in the same cycle and o_count stays 0.
